// File: rtl/btn_pulse_if.sv
`default_nettype none
// btn_pulse_if: button level in, timer settings in, registered event pulses out.
// `release` is a reserved word, so the release pulse travels as `rel`.
interface btn_pulse_if #(
    parameter int CNT_W = 32
);
    logic             d;
    logic [CNT_W-1:0] hold_time;
    logic [CNT_W-1:0] repeat_time;
    logic             level;
    logic             press;
    logic             rel;
    logic             long;
    logic             rpt;

    modport master (
        output d, hold_time, repeat_time,
        input  level, press, rel, long, rpt
    );

    modport slave (
        input  d, hold_time, repeat_time,
        output level, press, rel, long, rpt
    );
endinterface
`default_nettype wire

// File: rtl/btn_pulse.sv
`default_nettype none
// btn_pulse: debounced button level -> press/release/long-press/auto-repeat pulses.
// Auto-repeat is built only when BTN_PULSE_REPEAT_EN is defined; otherwise rpt is 0.
module btn_pulse #(
    parameter int CNT_W = 32
) (
    input  wire logic  clk,
    input  wire logic  arst,
    btn_pulse_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             level_q, press_q, rel_q, long_q, rpt_q;
    logic             long_nx, rpt_nx;
    logic             hold_on, hold_hit;
    logic             rep_on, rep_hit;

    // >= rather than == so a threshold lowered mid-count still fires promptly
    assign hold_on  = (bus.hold_time != '0);
    assign hold_hit = hold_on && (cnt >= bus.hold_time - ONE);

`ifdef BTN_PULSE_REPEAT_EN
    assign rep_on  = (bus.repeat_time != '0);
    assign rep_hit = rep_on && (cnt >= bus.repeat_time - ONE);
`else
    logic unused_repeat;
    assign rep_on        = 1'b0;
    assign rep_hit       = 1'b0;
    assign unused_repeat = ^bus.repeat_time;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        long_nx  = 1'b0;
        rpt_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.d && !level_q) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end
            end
            PRESSED: begin
                if (!bus.d) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (hold_hit) begin
                    state_nx = HELD;
                    long_nx  = 1'b1;
                    cnt_nx   = '0;
                end else if (hold_on) begin
                    cnt_nx = cnt + ONE;
                end
            end
            HELD: begin
                if (!bus.d) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (rep_hit) begin
                    rpt_nx = 1'b1;
                    cnt_nx = '0;
                end else if (rep_on) begin
                    cnt_nx = cnt + ONE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            state   <= IDLE;
            cnt     <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            level_q <= bus.d;
            press_q <= bus.d & ~level_q;
            rel_q   <= ~bus.d & level_q;
            long_q  <= long_nx;
            rpt_q   <= rpt_nx;
        end
    end

    assign bus.level = level_q;
    assign bus.press = press_q;
    assign bus.rel   = rel_q;
    assign bus.long  = long_q;
    assign bus.rpt   = rpt_q;
endmodule
`default_nettype wire

// File: doc/btn_pulse.md
# btn_pulse

- Converts a debounced push-button level into single-cycle events for control logic.
- Sits directly downstream of `debounce`: its `d` input is `debounce.q`.
- Events produced: press, release, long-press, and optional auto-repeat.
- Used by single-step/run control and front-panel register selection.

## Interface
Parameters:
- `CNT_W`, default 32: width of the internal cycle counter and of the `hold_time`/`repeat_time` ports.

Ports:
- `clk`  in  1: clock; all state changes on its rising edge.
- `arst`  in  1: reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `d`  in  1: debounced button level from `debounce.q`; already synchronous to `clk`.
- `hold_time`  in  CNT_W: cycles from press pulse to long-press pulse; 0 disables long-press and repeat.
- `repeat_time`  in  CNT_W: cycles between repeat pulses after long-press; 0 disables repeat.
- `level`  out  1: registered copy of `d`.
- `press`  out  1: one-cycle pulse on a 0→1 transition of `d`.
- `release`  out  1: one-cycle pulse on a 1→0 transition of `d`.
- `long`  out  1: one-cycle pulse when the button has been held `hold_time` cycles.
- `rpt`  out  1: one-cycle pulse every `repeat_time` cycles while held after `long`.

## Operation
State machine `IDLE`, `PRESSED`, `HELD`; counter `cnt` (CNT_W bits).

Every edge:
- `level <= d`
- `press <= d & ~level`
- `release <= ~d & level`

`IDLE`:
- On `d=1 & level=0`: go to `PRESSED`, `cnt <= 0`.

`PRESSED` (while `d=1`):
- If `hold_time != 0`: `cnt <= cnt+1`.
- When `cnt >= hold_time-1`: `long <= 1`, `cnt <= 0`, go to `HELD`.
- The `>=` compare covers `hold_time` being lowered mid-count.

`HELD` (while `d=1`):
- If `repeat_time != 0`: `cnt <= cnt+1`.
- When `cnt >= repeat_time-1`: `rpt <= 1`, `cnt <= 0`.
- If `repeat_time = 0`: `cnt` holds and `rpt` stays 0.

Release and reset:
- `d=0` in `PRESSED` or `HELD`: go to `IDLE`, `cnt <= 0`. No `long`/`rpt` is issued on that edge, even if a compare would match.
- `long` and `rpt` are otherwise 0. Each of them and `press`/`release` is high for at most one cycle per event.
- Counter never wraps: it is cleared on every match or release before reaching `2^CNT_W-1` (requires `hold_time`, `repeat_time` < `2^CNT_W`).
- Reset mid-operation: next edge returns to `IDLE` with all outputs 0. No `release` pulse is generated for the aborted press.

## Timing
- Reset (`arst=0` at an edge): `level=0`, `press=0`, `release=0`, `long=0`, `rpt=0`, `cnt=0`, state `IDLE`.
- `press`/`release`: high during the cycle after the first edge that samples the new `d` value (1-cycle latency).
- `long`: rises exactly `hold_time` edges after the edge that raised `press`.
- `rpt`: first pulse `repeat_time` edges after `long`, then every `repeat_time` edges.
- `press` and `release` are never high in the same cycle.
- `long` and `rpt` never coincide with `press` or `release`.
- A `d` low pulse of one cycle yields `release` then `press` on consecutive cycles, and restarts timing.
- All outputs are registered; no combinational path from `d` to outputs.

## Configuration
- `BTN_PULSE_REPEAT_EN` defined: auto-repeat as described.
- Undefined: `rpt` tied to 0. `HELD` is still entered on `long`, but `cnt` does not count there. `repeat_time` is ignored (port kept for pin compatibility).

## Test plan
- Reset: `arst=0` for 2 edges with `d=1` → all outputs 0 and no `press` while reset is low. After `arst=1` with `d` still 1 → `press` pulses once (level was reset to 0).
- Short press: `hold_time=20`, `d=1` for 10 cycles → `press` 1 cycle after rise, `release` 1 cycle after fall, no `long`.
- Long press with repeat: `hold_time=20`, `repeat_time=5`, `d=1` for 40 cycles → `long` 20 cycles after `press`, `rpt` at +5, +10, +15 after `long`, then `release`.
- Release on match: `hold_time=20`, drop `d` on the edge `long` would fire → `release` only, no `long`.
- Disabled timers: `hold_time=0`, `d=1` for 100 cycles → only `press`/`release`. Then `hold_time=20`, `repeat_time=0`, hold 100 cycles → one `long`, no `rpt`.
- Compile-out: without `BTN_PULSE_REPEAT_EN`, `hold_time=20`, `repeat_time=5`, hold 60 cycles → one `long`, `rpt` constantly 0.
